// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of the 4-group x 4-lane mux: arbitrates, settles selects, then streams a counted burst.
// Optional stall timeout with sticky err is compiled in with `define MUX_SCHED_TIMEOUT_EN; done/abort are registered pulses.
module mux_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
`ifdef MUX_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     req_lane,
    input  logic [LEN_W*N_REQ-1:0] req_len,
    input  logic                   out_ready,
    output logic [N_REQ-1:0]       grant,
    output logic [1:0]             sel_grp,
    output logic [1:0]             sel_lane,
    output logic                   mux_en,
    output logic                   done,
    output logic                   abort,
    output logic                   err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [1:0]         sel_grp_reg, sel_grp_next;
    logic [1:0]         sel_lane_reg, sel_lane_next;
    logic               mux_en_reg, mux_en_next;
    logic               done_reg, done_next;
    logic               abort_reg, abort_next;
    logic [1:0]         rr_ptr_reg, rr_ptr_next;
    logic [LEN_W-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [1:0]         lane_arr [N_REQ];
    logic [LEN_W-1:0]   len_arr  [N_REQ];
    logic               found;
    logic [1:0]         winner;
    logic [1:0]         scan_idx;
    logic               owner_req;
    logic               beat;
    logic               timeout_hit;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign lane_arr[gi] = req_lane[2*gi +: 2];
        assign len_arr[gi]  = req_len[LEN_W*gi +: LEN_W];
    end

    // First set request at or above rr_ptr, wrapping; the last winner sits at rr_ptr-1.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = rr_ptr_reg + 2'(k);
            if (!found && req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign owner_req = |(req & grant_reg);
    assign beat      = mux_en_reg & out_ready;

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_reg, stall_next;
    logic               err_reg, err_next;

    assign timeout_hit = (state_reg == XFER) && !out_ready && owner_req &&
                         (stall_reg == STALL_W'(TIMEOUT_CYC - 1));

    always_comb begin
        stall_next = stall_reg;
        err_next   = err_reg;
        if (state_reg == SETUP || beat) begin
            stall_next = '0;
        end else if (timeout_hit) begin
            stall_next = '0;
            err_next   = 1'b1;
        end else if (state_reg == XFER && owner_req) begin
            stall_next = stall_reg + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            stall_reg <= stall_next;
            err_reg   <= err_next;
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        sel_grp_next  = sel_grp_reg;
        sel_lane_next = sel_lane_reg;
        mux_en_next   = mux_en_reg;
        done_next     = 1'b0;
        abort_next    = 1'b0;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;

        case (state_reg)
            IDLE: begin
                grant_next  = '0;
                mux_en_next = 1'b0;
                if (found) begin
                    grant_next         = '0;
                    grant_next[winner] = 1'b1;
                    sel_grp_next       = winner;
                    sel_lane_next      = lane_arr[winner];
                    beat_cnt_next      = len_arr[winner];
                    rr_ptr_next        = winner + 2'd1;
                    state_next         = SETUP;
                end
            end
            SETUP: begin
                if (!owner_req) begin
                    abort_next = 1'b1;
                    grant_next = '0;
                    state_next = IDLE;
                end else begin
                    mux_en_next = 1'b1;
                    state_next  = XFER;
                end
            end
            XFER: begin
                // A beat accepted on the same cycle as a req drop still counts.
                if (beat) begin
                    if (beat_cnt_reg == '0) begin
                        done_next   = 1'b1;
                        grant_next  = '0;
                        mux_en_next = 1'b0;
                        state_next  = IDLE;
                    end else if (!owner_req) begin
                        abort_next  = 1'b1;
                        grant_next  = '0;
                        mux_en_next = 1'b0;
                        state_next  = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg - LEN_W'(1);
                    end
                end else if (!owner_req || timeout_hit) begin
                    abort_next  = 1'b1;
                    grant_next  = '0;
                    mux_en_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: begin
                grant_next  = '0;
                mux_en_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            sel_grp_reg  <= '0;
            sel_lane_reg <= '0;
            mux_en_reg   <= 1'b0;
            done_reg     <= 1'b0;
            abort_reg    <= 1'b0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            sel_grp_reg  <= sel_grp_next;
            sel_lane_reg <= sel_lane_next;
            mux_en_reg   <= mux_en_next;
            done_reg     <= done_next;
            abort_reg    <= abort_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    assign grant    = grant_reg;
    assign sel_grp  = sel_grp_reg;
    assign sel_lane = sel_lane_reg;
    assign mux_en   = mux_en_reg;
    assign done     = done_reg;
    assign abort    = abort_reg;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: a burst-level reference model queues expected grants and
// burst endings; a negedge monitor pops and compares them as the DUT presents them.
module tb_mux_rr_scheduler;

    localparam int TO_CYC   = 8;
    localparam int PH_IDLE  = 0;
    localparam int PH_SETUP = 1;
    localparam int PH_XFER  = 2;
    localparam int K_DONE   = 0;
    localparam int K_ABORT  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  req_lane = '0;
    logic [15:0] req_len = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  grant;
    logic [1:0]  sel_grp;
    logic [1:0]  sel_lane;
    logic        mux_en;
    logic        done;
    logic        abort;
    logic        err;

    mux_rr_scheduler #(
        .N_REQ(4),
        .LEN_W(4)
`ifdef MUX_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TO_CYC)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_lane(req_lane),
        .req_len(req_len),
        .out_ready(out_ready),
        .grant(grant),
        .sel_grp(sel_grp),
        .sel_lane(sel_lane),
        .mux_en(mux_en),
        .done(done),
        .abort(abort),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int owner; int lane; int cyc;} grant_exp_t;
    typedef struct {int kind; int owner; int lane; int beats; int cyc;} end_exp_t;

    grant_exp_t grant_q[$];
    end_exp_t   end_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model state (burst-level view of the scheduler)
    int m_phase = PH_IDLE;
    int m_owner = 0;
    int m_lane  = 0;
    int m_left  = 0;
    int m_beats = 0;
    int m_stall = 0;
    int m_ptr   = 0;
    bit m_err   = 1'b0;
    bit exp_mux_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic end_burst(input int kind);
        end_q.push_back('{kind, m_owner, m_lane, m_beats, cyc});
        req[m_owner] = 1'b0;
        m_phase = PH_IDLE;
    endtask

    // Advance one clock; the model judges the cycle that just ended from the inputs it was given.
    task automatic tick();
        bit got;
        @(posedge clk);
        #1;
        case (m_phase)
            PH_IDLE: begin
                got = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!got && req[(m_ptr + k) % 4]) begin
                        got = 1'b1;
                        m_owner = (m_ptr + k) % 4;
                    end
                end
                if (got) begin
                    m_lane  = int'(req_lane[2*m_owner +: 2]);
                    m_left  = int'(req_len[4*m_owner +: 4]);
                    m_beats = 0;
                    m_stall = 0;
                    m_ptr   = (m_owner + 1) % 4;
                    m_phase = PH_SETUP;
                    grant_q.push_back('{m_owner, m_lane, cyc});
                end
            end
            PH_SETUP: begin
                if (!req[m_owner]) end_burst(K_ABORT);
                else m_phase = PH_XFER;
            end
            default: begin
                if (out_ready) begin
                    m_beats++;
                    m_stall = 0;
                    if (m_left == 0) end_burst(K_DONE);
                    else if (!req[m_owner]) end_burst(K_ABORT);
                    else m_left--;
                end else if (!req[m_owner]) begin
                    end_burst(K_ABORT);
                end
`ifdef MUX_SCHED_TIMEOUT_EN
                else begin
                    m_stall++;
                    if (m_stall == TO_CYC) begin
                        m_err = 1'b1;
                        end_burst(K_ABORT);
                    end
                end
`endif
            end
        endcase
        exp_mux_en = (m_phase == PH_XFER);
    endtask

    task automatic drive_random();
        for (int i = 0; i < 4; i++) begin
            if (m_phase != PH_IDLE && i == m_owner) begin
                if ($urandom_range(99) < 3) req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(99) < 30) begin
                req[i] = 1'b1;
            end
        end
        req_lane  = 8'($urandom);
        req_len   = 16'($urandom);
        out_ready = ($urandom_range(99) < 75);
    endtask

    // Let the current owner finish with out_ready high, then idle so the monitor sees the pulse.
    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 40 && m_phase != PH_IDLE; n++) begin
            req = 4'(1 << m_owner);
            tick();
        end
        req = '0;
        tick();
        tick();
    endtask

    // Monitor: pops the scoreboard whenever a grant appears or a burst ends
    logic [3:0] prev_grant = '0;
    int         beats_seen = 0;
    grant_exp_t gx;
    end_exp_t   ex;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_grant = '0;
            beats_seen = 0;
        end else begin
            chk("mux_en", int'(mux_en), int'(exp_mux_en));
            chk("err", int'(err), int'(m_err));
            chk("done_with_abort", int'(done & abort), 0);
            if (grant != '0 && prev_grant == '0) begin
                chk("grant_expected", int'(grant_q.size() != 0), 1);
                if (grant_q.size() != 0) begin
                    gx = grant_q.pop_front();
                    chk("grant", int'(grant), 1 << gx.owner);
                    chk("sel_grp", int'(sel_grp), gx.owner);
                    chk("sel_lane", int'(sel_lane), gx.lane);
                    chk("grant_cycle", cyc, gx.cyc);
                end
            end
            if (mux_en && out_ready) beats_seen++;
            if (done || abort) begin
                chk("end_expected", int'(end_q.size() != 0), 1);
                if (end_q.size() != 0) begin
                    ex = end_q.pop_front();
                    chk("end_kind_abort", int'(abort), ex.kind);
                    chk("end_beats", beats_seen, ex.beats);
                    chk("end_cycle", cyc, ex.cyc);
                    chk("end_grant_clear", int'(grant), 0);
                    chk("end_sel_grp_kept", int'(sel_grp), ex.owner);
                    chk("end_sel_lane_kept", int'(sel_lane), ex.lane);
                end
                beats_seen = 0;
            end
            prev_grant = grant;
        end
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_sel_grp", int'(sel_grp), 0);
        chk("rst_sel_lane", int'(sel_lane), 0);
        chk("rst_mux_en", int'(mux_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_abort", int'(abort), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        tick();

        // Single 3-beat burst on requester 2, lane 3; later lane/len changes must be ignored
        req = 4'b0100; req_lane = 8'h30; req_len = 16'h0200; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            req_lane = 8'($urandom);
            req_len  = 16'($urandom);
            tick();
        end

        // Reset in the middle of a transfer
        req = 4'b0010; req_lane = 8'($urandom); req_len = 16'h0070; out_ready = 1'b1;
        repeat (4) tick();
        chk("pre_rst_mux_en", int'(mux_en), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_mux_en", int'(mux_en), 0);
        chk("midrst_done", int'(done), 0);
        grant_q.delete();
        end_q.delete();
        m_phase = PH_IDLE; m_ptr = 0; m_err = 1'b0; exp_mux_en = 1'b0;
        req = 4'hF; req_len = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin, everyone requesting single-beat bursts
        for (int i = 0; i < 15; i++) begin
            tick();
            req = 4'hF; req_len = '0; req_lane = 8'($urandom);
        end
        drain();

        // Backpressure: 2-beat burst with 5 stalled cycles between the beats
        req = 4'b0010; req_len = 16'h0010; req_lane = 8'($urandom); out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        drain();

        // Abort in SETUP
        req = 4'b0001; req_lane = 8'($urandom); req_len = 16'h0003;
        tick();
        req = '0;
        tick();
        tick();

        // Abort in XFER after one beat, another requester waiting
        req = 4'b0101; req_len = 16'h3333; req_lane = 8'($urandom); out_ready = 1'b1;
        tick();
        tick();
        tick();
        req[m_owner] = 1'b0; out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        drain();

        // Long stall inside XFER
        req = 4'b1000; req_len = 16'hF000; req_lane = 8'($urandom); out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        repeat (100) tick();
`ifdef MUX_SCHED_TIMEOUT_EN
        chk("timeout_err", int'(err), 1);
        chk("timeout_grant", int'(grant), 0);
`else
        chk("stall_hold_mux_en", int'(mux_en), 1);
        chk("stall_no_err", int'(err), 0);
`endif
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive_random();
        end
        drain();

        chk("grant_q_empty", grant_q.size(), 0);
        chk("end_q_empty", end_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
